// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the simpleCNN front end.
package cnn_pkg;

  localparam int PIX_W = 8;
  localparam int NPIX  = 25;
  localparam int IMG_W = PIX_W * NPIX;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/img_frame_loader.sv
// Packs a byte-serial pixel stream into one 5x5 frame, fires START once the
// frame is complete and holds the frame stable until the CNN reports DONE.
module img_frame_loader
  import cnn_pkg::*;
#(
  parameter int PIX_W_P = PIX_W,
  parameter int NPIX_P  = NPIX
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PIX_W_P-1:0]        PIX_IN,
  input  logic                      PIX_VALID,
  input  logic                      PIX_SOF,
  output logic                      PIX_READY,
  input  logic                      CNN_DONE,
  output logic [PIX_W_P*NPIX_P-1:0] IMGIN,
  output logic                      START,
  output logic                      BUSY,
  output logic [7:0]                FRAME_CNT
);

  localparam int IDX_W = $clog2(NPIX_P);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX_P - 1);

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [PIX_W_P*NPIX_P-1:0]   imgin_q, imgin_d;
  logic                        ready_q, ready_d;
  logic                        start_q, start_d;
  logic                        busy_q, busy_d;
  logic [7:0]                  frame_cnt_q, frame_cnt_d;
  logic                        accept;

  // A pixel is taken only while the loader advertises READY, which is LOAD-only.
  assign accept = PIX_VALID && ready_q && (state_q == LOAD);

  // State and output registers; every output is a flop so nothing leaks combinationally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      imgin_q     <= '0;
      ready_q     <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      imgin_q     <= imgin_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic: DONE is only looked at in WAIT, so a DONE during FIRE is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && !PIX_SOF && (idx_q == LAST_IDX)) state_d = FIRE;
      FIRE:    state_d = WAIT;
      WAIT:    if (CNN_DONE) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Pixel packing and frame counting; SOF restarts the write pointer at pixel 0.
  always_comb begin
    idx_d       = idx_q;
    imgin_d     = imgin_q;
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      if (PIX_SOF) begin
        imgin_d[0 +: PIX_W_P] = PIX_IN;
        idx_d                 = IDX_W'(1);
      end else begin
        imgin_d[idx_q*PIX_W_P +: PIX_W_P] = PIX_IN;
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
    end
    if ((state_q == WAIT) && CNN_DONE) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Registered outputs derived from the upcoming state. READY waits one full
  // cycle in LOAD before rising, giving the two-cycle DONE-to-accept gap.
  always_comb begin
    ready_d = (state_q == LOAD) && (state_d == LOAD);
    start_d = (state_d == FIRE);
    busy_d  = (state_d == FIRE) || (state_d == WAIT);
  end

  assign PIX_READY = ready_q;
  assign IMGIN     = imgin_q;
  assign START     = start_q;
  assign BUSY      = busy_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_img_frame_loader.sv
// Directed bench for img_frame_loader: packing, gaps, resync, WAIT hold,
// async reset and FRAME_CNT wrap.
module tb_img_frame_loader;
  import cnn_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       pix_in;
  logic             pix_valid;
  logic             pix_sof;
  logic             pix_ready;
  logic             cnn_done;
  logic [IMG_W-1:0] imgin;
  logic             start;
  logic             busy;
  logic [7:0]       frame_cnt;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  logic [IMG_W-1:0] exp_img;
  logic [IMG_W-1:0] ramp_img;

  img_frame_loader dut (
    .CLK       (clk),
    .RST       (rst),
    .PIX_IN    (pix_in),
    .PIX_VALID (pix_valid),
    .PIX_SOF   (pix_sof),
    .PIX_READY (pix_ready),
    .CNN_DONE  (cnn_done),
    .IMGIN     (imgin),
    .START     (start),
    .BUSY      (busy),
    .FRAME_CNT (frame_cnt)
  );

  always #5 clk = ~clk;

  // Count START-high cycles, sampled mid-cycle.
  always @(negedge clk) if (start === 1'b1) start_cnt++;

  // Offer one pixel; returns at the negedge after it is accepted, with VALID dropped.
  task automatic send_pix(input logic [7:0] d, input logic s);
    int t = 0;
    while (pix_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t >= 200) begin
      bad++;
      $display("FAIL ready_timeout actual=%b required=1", pix_ready);
    end
    pix_in = d;
    pix_valid = 1'b1;
    pix_sof = s;
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic send_ramp(input logic [7:0] base);
    for (int k = 0; k < NPIX; k++) send_pix(base + 8'(k), k == 0);
  endtask

  task automatic pulse_done();
    cnn_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cnn_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (imgin !== '0) begin bad++; $display("FAIL rst_imgin actual=%h required=0", imgin); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL rst_start actual=%b required=0", start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy actual=%b required=0", busy); end
    total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL rst_ready actual=%b required=0", pix_ready); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_fcnt actual=%0d required=0", frame_cnt); end
    do_reset();
    total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after actual=%b required=1", pix_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    start_cnt = 0;
    send_ramp(8'h00);
    total++; if (imgin[7:0] !== 8'h00) begin bad++; $display("FAIL basic_byte0 actual=%h required=00", imgin[7:0]); end
    total++; if (imgin[199:192] !== 8'h18) begin bad++; $display("FAIL basic_byte24 actual=%h required=18", imgin[199:192]); end
    total++; if (imgin !== ramp_img) begin bad++; $display("FAIL basic_imgin actual=%h required=%h", imgin, ramp_img); end
    total++; if (start !== 1'b1) begin bad++; $display("FAIL basic_start actual=%b required=1", start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy actual=%b required=1", busy); end
    @(negedge clk);
    total++; if (start !== 1'b0) begin bad++; $display("FAIL basic_start_off actual=%b required=0", start); end
    total++; if (start_cnt !== 1) begin bad++; $display("FAIL basic_start_cnt actual=%0d required=1", start_cnt); end
    pulse_done();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_off actual=%b required=0", busy); end
    total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL basic_fcnt actual=%0d required=1", frame_cnt); end
    $display("test_basic done");
  endtask

  task automatic test_gaps();
    start_cnt = 0;
    for (int k = 0; k < NPIX; k++) begin
      send_pix(8'(k), k == 0);
      if (k < NPIX - 1) @(negedge clk);
    end
    total++; if (start !== 1'b1) begin bad++; $display("FAIL gaps_start actual=%b required=1", start); end
    total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL gaps_ready_fire actual=%b required=0", pix_ready); end
    @(negedge clk);
    total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL gaps_ready_wait actual=%b required=0", pix_ready); end
    total++; if (imgin !== ramp_img) begin bad++; $display("FAIL gaps_imgin actual=%h required=%h", imgin, ramp_img); end
    total++; if (start_cnt !== 1) begin bad++; $display("FAIL gaps_start_cnt actual=%0d required=1", start_cnt); end
    pulse_done();
    total++; if (frame_cnt !== 8'd2) begin bad++; $display("FAIL gaps_fcnt actual=%0d required=2", frame_cnt); end
    $display("test_gaps done");
  endtask

  task automatic test_resync();
    start_cnt = 0;
    for (int k = 0; k < 10; k++) send_pix(8'h50 + 8'(k), k == 0);
    send_pix(8'hAA, 1'b1);
    for (int k = 0; k < NPIX - 1; k++) send_pix(8'h01, 1'b0);
    for (int k = 0; k < NPIX; k++) exp_img[k*8 +: 8] = (k == 0) ? 8'hAA : 8'h01;
    total++; if (start !== 1'b1) begin bad++; $display("FAIL resync_start actual=%b required=1", start); end
    @(negedge clk);
    total++; if (imgin !== exp_img) begin bad++; $display("FAIL resync_imgin actual=%h required=%h", imgin, exp_img); end
    total++; if (start_cnt !== 1) begin bad++; $display("FAIL resync_start_cnt actual=%0d required=1", start_cnt); end
    pulse_done();
    $display("test_resync done");
  endtask

  task automatic test_wait_hold();
    int rdy_seen = 0;
    do_reset();
    start_cnt = 0;
    send_ramp(8'h00);
    pix_in = 8'hFF;
    pix_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pix_ready !== 1'b0) rdy_seen++;
    end
    pix_valid = 1'b0;
    total++; if (rdy_seen !== 0) begin bad++; $display("FAIL hold_ready actual=%0d required=0", rdy_seen); end
    total++; if (imgin !== ramp_img) begin bad++; $display("FAIL hold_imgin actual=%h required=%h", imgin, ramp_img); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy actual=%b required=1", busy); end
    pulse_done();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy_off actual=%b required=0", busy); end
    total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL hold_fcnt actual=%0d required=1", frame_cnt); end
    @(negedge clk);
    total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_back actual=%b required=1", pix_ready); end
    $display("test_wait_hold done");
  endtask

  task automatic test_done_in_fire();
    cnn_done = 1'b1;
    send_ramp(8'h30);
    total++; if (start !== 1'b1) begin bad++; $display("FAIL fire_done_start actual=%b required=1", start); end
    @(negedge clk);
    cnn_done = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fire_done_busy actual=%b required=1", busy); end
    total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL fire_done_fcnt actual=%0d required=1", frame_cnt); end
    pulse_done();
    total++; if (frame_cnt !== 8'd2) begin bad++; $display("FAIL fire_done_fcnt2 actual=%0d required=2", frame_cnt); end
    $display("test_done_in_fire done");
  endtask

  task automatic test_async_reset();
    do_reset();
    start_cnt = 0;
    for (int k = 0; k < 12; k++) send_pix(8'h80 + 8'(k), k == 0);
    #1 rst = 1'b1;
    #1;
    total++; if (imgin !== '0) begin bad++; $display("FAIL arst_load_imgin actual=%h required=0", imgin); end
    total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL arst_load_ready actual=%b required=0", pix_ready); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    total++; if (start_cnt !== 0) begin bad++; $display("FAIL arst_partial_start actual=%0d required=0", start_cnt); end
    send_ramp(8'h40);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (imgin !== '0) begin bad++; $display("FAIL arst_wait_imgin actual=%h required=0", imgin); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_wait_busy actual=%b required=0", busy); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL arst_wait_start actual=%b required=0", start); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    start_cnt = 0;
    send_ramp(8'h00);
    total++; if (start !== 1'b1) begin bad++; $display("FAIL arst_next_start actual=%b required=1", start); end
    total++; if (imgin !== ramp_img) begin bad++; $display("FAIL arst_next_imgin actual=%h required=%h", imgin, ramp_img); end
    pulse_done();
    total++; if (start_cnt !== 1) begin bad++; $display("FAIL arst_next_start_cnt actual=%0d required=1", start_cnt); end
    $display("test_async_reset done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_cnt = 0;
    for (int f = 0; f < 256; f++) begin
      send_ramp(8'(f));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      pulse_done();
      if (f == 254) begin
        total++; if (frame_cnt !== 8'd255) begin bad++; $display("FAIL b2b_fcnt255 actual=%0d required=255", frame_cnt); end
      end
    end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL b2b_wrap actual=%0d required=0", frame_cnt); end
    total++; if (start_cnt !== 256) begin bad++; $display("FAIL b2b_start_cnt actual=%0d required=256", start_cnt); end
    total++; if (imgin[7:0] !== 8'hFF) begin bad++; $display("FAIL b2b_byte0 actual=%h required=ff", imgin[7:0]); end
    total++; if (imgin[199:192] !== 8'h17) begin bad++; $display("FAIL b2b_byte24 actual=%h required=17", imgin[199:192]); end
    $display("test_back_to_back done");
  endtask

  initial begin
    rst = 1'b1;
    pix_in = 8'h00;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    cnn_done = 1'b0;
    exp_img = '0;
    for (int k = 0; k < NPIX; k++) ramp_img[k*8 +: 8] = 8'(k);
    test_reset();
    test_basic();
    test_gaps();
    test_resync();
    test_wait_hold();
    test_done_in_fire();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
